// File: rtl/ppu_pkg.sv
// Shared PPU types: OAM constants, sprite buffer entry, scanner states.
// Used by the OAM scanner and the sprite fetcher.
package ppu_pkg;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_ENTRIES = 40;
  localparam int          BUF_DEPTH   = 10;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] obj;
    logic [3:0] row;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_Y,
    S_READ_X,
    S_DRAIN
  } scan_state_e;

endpackage

// File: rtl/oam_y_matcher.sv
// Vertical hit test of one OAM object against the current scanline.
// diff = ly + 16 - Y in 9 bits; a borrow lands far above any height.
module oam_y_matcher (
  input  logic [7:0] y_i,
  input  logic [7:0] ly_i,
  input  logic       tall_i,
  output logic       hit_o,
  output logic [3:0] row_o
);

  logic [8:0] diff;
  logic [8:0] height;
  logic       y_ok;

  assign diff   = {1'b0, ly_i} + 9'd16 - {1'b0, y_i};
  assign height = tall_i ? 9'd16 : 9'd8;
  assign y_ok   = (y_i != 8'd0) && (y_i < 8'd160);
  assign hit_o  = y_ok && (diff < height);
  assign row_o  = diff[3:0];

endmodule

// File: rtl/oam_scanner.sv
// Mode-2 OAM scan: two reads per object, hits committed in OAM order
// into a fixed sprite buffer for the fetcher.
module oam_scanner
  import ppu_pkg::*;
#(
  parameter int OAM_ENTRIES = ppu_pkg::OAM_ENTRIES,
  parameter int BUF_DEPTH   = ppu_pkg::BUF_DEPTH
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           tclk_in,
  input  logic                           start_in,
  input  logic [7:0]                     ly_in,
  input  logic                           tall_sprite_mode_in,
  output logic [15:0]                    oam_addr_out,
  output logic                           oam_req_out,
  input  logic [7:0]                     oam_data_in,
  input  logic                           oam_valid_in,
  output sprite_entry_t [BUF_DEPTH-1:0]  sprite_buffer_out,
  output logic [3:0]                     sprite_count_out,
  output logic                           busy_out,
  output logic                           done_out
);

  localparam logic [5:0] N_LAST  = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] CNT_MAX = 4'(BUF_DEPTH);

  scan_state_e state_q, state_d;

  logic [5:0]    n_q;
  logic [5:0]    obj_q;
  logic [3:0]    row_q;
  logic          pend_q;
  logic [3:0]    count_q;
  logic          done_q;
  sprite_entry_t [BUF_DEPTH-1:0] buf_q;

  logic [7:0] rd_byte;
  logic       hit;
  logic [3:0] row;
  logic       last;
  logic       room;

  assign rd_byte = oam_valid_in ? oam_data_in : 8'hFF;
  assign last    = (n_q == N_LAST);
  assign room    = (count_q < CNT_MAX);

  oam_y_matcher u_match (
    .y_i    (rd_byte),
    .ly_i   (ly_in),
    .tall_i (tall_sprite_mode_in),
    .hit_o  (hit),
    .row_o  (row)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tclk_in) begin
      if (start_in) begin
        state_d = S_READ_Y;
      end else begin
        unique case (state_q)
          S_IDLE:   state_d = S_IDLE;
          S_READ_Y: state_d = S_READ_X;
          S_READ_X: state_d = last ? S_DRAIN : S_READ_Y;
          S_DRAIN:  state_d = S_IDLE;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    oam_req_out  = 1'b0;
    oam_addr_out = 16'h0;
    unique case (state_q)
      S_READ_Y: begin
        oam_req_out  = 1'b1;
        oam_addr_out = OAM_BASE + {8'h0, n_q, 2'b00};
      end
      S_READ_X: begin
        oam_req_out  = 1'b1;
        oam_addr_out = OAM_BASE + {8'h0, n_q, 2'b01};
      end
      default: ;
    endcase
  end

  assign busy_out          = (state_q != S_IDLE);
  assign done_out          = done_q;
  assign sprite_count_out  = count_q;
  assign sprite_buffer_out = buf_q;

  // X of the previous object arrives in ReadY/Drain; commit there
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_q     <= '0;
      obj_q   <= '0;
      row_q   <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      buf_q   <= '0;
    end else if (tclk_in) begin
      done_q <= 1'b0;
      if (start_in) begin
        n_q     <= '0;
        pend_q  <= 1'b0;
        count_q <= '0;
        buf_q   <= '0;
      end else begin
        unique case (state_q)
          S_READ_Y, S_DRAIN: begin
            if (pend_q && room) begin
              buf_q[count_q] <= '{x: rd_byte,
                                  obj: obj_q,
                                  row: row_q};
              count_q <= count_q + 4'd1;
            end
            pend_q <= 1'b0;
            if (state_q == S_DRAIN) done_q <= 1'b1;
          end
          S_READ_X: begin
            pend_q <= hit;
            row_q  <= row;
            obj_q  <= n_q;
            if (!last) n_q <= n_q + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_scanner.sv
// Randomized bench for oam_scanner with an OAM responder and a
// list-based reference of which objects land in the sprite buffer.
module tb_oam_scanner;

  logic             clk = 1'b0;
  logic             rst_n_in;
  logic             tclk_in;
  logic             start_in;
  logic [7:0]       ly_in;
  logic             tall_in;
  logic [15:0]      oam_addr_out;
  logic             oam_req_out;
  logic [7:0]       oam_data_in;
  logic             oam_valid_in;
  logic [9:0][17:0] sbuf;
  logic [3:0]       sprite_count_out;
  logic             busy_out;
  logic             done_out;

  oam_scanner dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n_in),
    .tclk_in             (tclk_in),
    .start_in            (start_in),
    .ly_in               (ly_in),
    .tall_sprite_mode_in (tall_in),
    .oam_addr_out        (oam_addr_out),
    .oam_req_out         (oam_req_out),
    .oam_data_in         (oam_data_in),
    .oam_valid_in        (oam_valid_in),
    .sprite_buffer_out   (sbuf),
    .sprite_count_out    (sprite_count_out),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [160];
  bit          inval [40];
  logic [17:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one T-cycle: tclk edge, then an idle clk edge; OAM answers next tclk
  task automatic tick();
    logic        req;
    logic [15:0] a;
    int          idx;
    req = oam_req_out;
    a   = oam_addr_out;
    tclk_in = 1'b1;
    @(posedge clk);
    #1;
    tclk_in = 1'b0;
    idx = int'(a) - 'hFE00;
    if (req && idx >= 0 && idx < 160) begin
      oam_data_in  = mem[idx];
      oam_valid_in = !inval[idx / 4];
    end else begin
      oam_data_in  = 8'($urandom);
      oam_valid_in = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model();
    int y, x, d, h;
    exp_q.delete();
    h = tall_in ? 16 : 8;
    for (int i = 0; i < 40; i++) begin
      y = inval[i] ? 255 : int'(mem[4*i]);
      x = inval[i] ? 255 : int'(mem[4*i+1]);
      d = int'(ly_in) + 16 - y;
      if (y != 0 && y < 160 && d >= 0 && d < h && exp_q.size() < 10)
        exp_q.push_back({x[7:0], 6'(i), d[3:0]});
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) mem[i] = 8'h00;
    for (int i = 0; i < 40; i++) inval[i] = 1'b0;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!done_out && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 81);
  endtask

  task automatic check_buf(input string tag);
    logic [17:0] e;
    model();
    chk({tag, "_cnt"}, sprite_count_out, exp_q.size());
    for (int i = 0; i < 10; i++) begin
      e = (i < exp_q.size()) ? exp_q[i] : 18'h0;
      chk($sformatf("%s_slot%0d", tag, i), sbuf[i], e);
    end
  endtask

  task automatic post_done(input string tag);
    logic [3:0] c;
    c = sprite_count_out;
    tick();
    chk({tag, "_pulse"}, done_out, 0);
    chk({tag, "_idle"}, busy_out, 0);
    for (int i = 0; i < 3; i++) begin
      ly_in = 8'($urandom);
      tick();
    end
    chk({tag, "_hold"}, sprite_count_out, c);
  endtask

  task automatic full_scan(input string tag);
    do_start();
    wait_done(tag);
    check_buf(tag);
    post_done(tag);
  endtask

  task automatic rand_oam(input int hit_pct);
    int y;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(99) < hit_pct)
        y = int'(ly_in) + 16 - $urandom_range(0, 17);
      else
        y = $urandom_range(0, 255);
      mem[4*i]   = 8'(y);
      mem[4*i+1] = ($urandom_range(7) == 0) ? 8'h0 : 8'($urandom);
      mem[4*i+2] = 8'($urandom);
      mem[4*i+3] = 8'($urandom);
      inval[i]   = ($urandom_range(15) == 0);
    end
  endtask

  initial begin
    int seen;
    rst_n_in = 1'b0;
    tclk_in = 1'b0;
    start_in = 1'b0;
    ly_in = 8'd0;
    tall_in = 1'b0;
    oam_data_in = 8'h0;
    oam_valid_in = 1'b0;
    clear_oam();
    #1;
    chk("rst_cnt", sprite_count_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_req", oam_req_out, 0);
    chk("rst_addr", oam_addr_out, 0);
    chk("rst_buf", sbuf, 0);
    #13 rst_n_in = 1'b1;
    @(posedge clk);
    #1;

    // single hit on line 0
    mem[20] = 8'd16;
    mem[21] = 8'd40;
    full_scan("one");
    chk("one_slot0", sbuf[0], {8'd40, 6'd5, 4'd0});

    // overflow: 12 hits, only first 10 kept
    clear_oam();
    ly_in = 8'd20;
    for (int i = 0; i < 12; i++) begin
      mem[4*i]   = 8'd30;
      mem[4*i+1] = 8'(8 + i);
    end
    full_scan("ovf");
    chk("ovf_slot9", sbuf[9], {8'd17, 6'd9, 4'd6});

    // tall vs short objects
    clear_oam();
    ly_in = 8'd10;
    mem[0] = 8'd12;
    mem[1] = 8'd99;
    tall_in = 1'b1;
    full_scan("tall");
    chk("tall_row", sbuf[0], {8'd99, 6'd0, 4'd14});
    tall_in = 1'b0;
    full_scan("short");
    chk("short_cnt", sprite_count_out, 0);

    // invalid read on object 3 masks a hit
    mem[12] = 8'd20;
    mem[13] = 8'd50;
    inval[3] = 1'b1;
    full_scan("inval");
    chk("inval_cnt", sprite_count_out, 0);

    for (int k = 0; k < 6; k++) begin
      ly_in = 8'($urandom_range(0, 159));
      tall_in = 1'($urandom);
      rand_oam(40);
      full_scan($sformatf("rnd%0d", k));
    end

    // restart mid-scan
    ly_in = 8'd50;
    tall_in = 1'b1;
    rand_oam(70);
    do_start();
    repeat (39) tick();
    do_start();
    chk("abort_cnt", sprite_count_out, 0);
    chk("abort_busy", busy_out, 1);
    wait_done("abort");
    check_buf("abort");
    post_done("abort");

    // async reset mid-scan
    do_start();
    repeat (30) tick();
    #3 rst_n_in = 1'b0;
    #1;
    chk("mrst_cnt", sprite_count_out, 0);
    chk("mrst_busy", busy_out, 0);
    chk("mrst_req", oam_req_out, 0);
    chk("mrst_addr", oam_addr_out, 0);
    chk("mrst_buf", sbuf, 0);
    #2 rst_n_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_out) seen++;
    end
    chk("mrst_nodone", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
